// File: rtl/fns_cac_encoder_seq.sv
// Sequential FNS crosstalk-avoidance encoder: DATA_W-bit word to CODE_W-digit codeword, one digit per cycle, MSB first.
// Latency CODE_W cycles from accept to out_valid; throughput one word per CODE_W+1 cycles.
// Backpressure: codeout held while out_valid & !out_ready; in_ready low in CALC. FNS_CAC_ENC_SELFCHECK_EN adds the err port.
module fns_cac_encoder_seq #(
  parameter int DATA_W = 10,
  parameter int CODE_W = 14
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W:1]   codeout,
  output logic              busy
`ifdef FNS_CAC_ENC_SELFCHECK_EN
  ,
  output logic              err
`endif
);

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int RES_W = $clog2(fib(CODE_W + 3));
  localparam int K_W   = $clog2(CODE_W + 2);

  if (((64'd1 << DATA_W) - 64'd1) > (fib(CODE_W + 3) - 64'd2)) begin : g_width_check
    $error("fns_cac_encoder_seq: CODE_W too small for DATA_W");
  end

  // w_tab[k] = F(k+1); entry 0 is a harmless filler for idle-state lookups.
  logic [RES_W-1:0] w_tab [0:CODE_W+1];
  assign w_tab[0] = '0;
  for (genvar g = 1; g <= CODE_W + 1; g++) begin : g_w
    assign w_tab[g] = RES_W'(fib(g + 1));
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RES_W-1:0]  r_q, r_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              p_q, p_d;
  logic [CODE_W-1:0] sh_q, sh_d;
  logic [CODE_W:1]   code_q, code_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
`endif

  logic [RES_W-1:0]  w_k, w_k1, r_sub;
  logic [CODE_W-1:0] sh_next;
  logic              dig;
  logic              load;

  always_comb begin
    w_k  = w_tab[k_q];
    w_k1 = w_tab[k_q + K_W'(1)];
    // Greedy with run preservation: in the overlap band repeat the previous digit.
    if (r_q >= w_k1 - RES_W'(1)) begin
      dig = 1'b1;
    end else if (r_q < w_k) begin
      dig = 1'b0;
    end else begin
      dig = p_q;
    end
    r_sub   = dig ? (r_q - w_k) : r_q;
    sh_next = {sh_q[CODE_W-2:0], dig};
    load    = in_valid & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));

    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    p_d     = p_q;
    sh_d    = sh_q;
    code_d  = code_q;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
    acc_d   = acc_q;
    data_d  = data_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: state_d = state_q;
      S_CALC: begin
        r_d  = r_sub;
        p_d  = dig;
        sh_d = sh_next;
        k_d  = k_q - K_W'(1);
`ifdef FNS_CAC_ENC_SELFCHECK_EN
        acc_d = acc_q + (dig ? w_k : '0);
`endif
        if (k_q == K_W'(1)) begin
          state_d = S_DONE;
          code_d  = sh_next;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
          err_d   = (acc_d != RES_W'(data_q)) | (r_sub != '0);
`endif
        end
      end
      S_DONE: begin
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_CALC;
      r_d     = RES_W'(datain);
      k_d     = K_W'(CODE_W);
      p_d     = 1'b0;
      sh_d    = '0;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
      acc_d   = '0;
      data_d  = datain;
`endif
    end

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_CALC);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      k_q         <= '0;
      p_q         <= 1'b0;
      sh_q        <= '0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
      acc_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      p_q         <= p_d;
      sh_q        <= sh_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
      acc_q       <= acc_d;
      data_q      <= data_d;
      err_q       <= err_d;
`endif
    end
  end

  // DONE accepts a new word in the same cycle the current codeword drains.
  assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign out_valid = out_valid_q;
  assign codeout   = code_q;
  assign busy      = busy_q;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_fns_cac_encoder_seq.sv
// Bench for fns_cac_encoder_seq: fixed vectors, exhaustive words with random stalls, back-to-back stream, mid-CALC reset.
module tb_fns_cac_encoder_seq;
  localparam int DW = 10;
  localparam int CW = 14;

  logic          clock;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [CW:1]   codeout;
  logic          busy;
`ifdef FNS_CAC_ENC_SELFCHECK_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;

  fns_cac_encoder_seq #(.DATA_W(DW), .CODE_W(CW)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .out_valid(out_valid), .out_ready(out_ready),
    .codeout(codeout), .busy(busy)
`ifdef FNS_CAC_ENC_SELFCHECK_EN
    , .err(err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int fibn(input int n);
    int a, b, t;
    a = 1;
    b = 1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Reference: digit k has weight F(k+1); walk the greedy rule over plain integers.
  function automatic logic [CW:1] model_code(input int d);
    logic [CW:1] c;
    int r;
    bit p, dg;
    r = d;
    p = 1'b0;
    c = '0;
    for (int k = CW; k >= 1; k--) begin
      if (r >= fibn(k + 2) - 1) dg = 1'b1;
      else if (r < fibn(k + 1)) dg = 1'b0;
      else dg = p;
      if (dg) r = r - fibn(k + 1);
      c[k] = dg;
      p = dg;
    end
    return c;
  endfunction

  function automatic int decode(input logic [CW:1] c);
    int s;
    s = 0;
    for (int k = 1; k <= CW; k++) if (c[k]) s = s + fibn(k + 1);
    return s;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the output drained.
  task automatic do_word(input logic [DW-1:0] d, input logic [CW:1] exp, input int max_stall);
    int n;
    int stall;
    logic [CW:1] held;
    bit hold_ok;
    datain   = d;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
    datain   = DW'($urandom);
    chk("busy_in_calc", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("latency", n, CW);
    chk("codeout", codeout, exp);
    chk("decode_sum", decode(codeout), d);
`ifdef FNS_CAC_ENC_SELFCHECK_EN
    chk("err_clean", err, 0);
`endif
    held = codeout;
    hold_ok = 1'b1;
    stall = $urandom_range(0, max_stall);
    repeat (stall) begin
      @(negedge clock);
      if (codeout !== held || out_valid !== 1'b1) hold_ok = 1'b0;
    end
    chk("hold_while_stalled", hold_ok, 1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("drained_to_idle", out_valid, 0);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [CW:1]   code;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int cyc, acc_n, rx_n, last_acc;
    bit started, acc_now;
    logic [DW-1:0] words [8];
    logic [DW-1:0] expq [$];

    tbl[0] = '{d: 10'd0, code: 14'h0000};
    tbl[1] = '{d: 10'd1, code: 14'h0001};
    tbl[2] = '{d: 10'd2, code: 14'h0002};
    tbl[3] = '{d: 10'd3, code: 14'h0003};
    tbl[4] = '{d: 10'd4, code: 14'h0005};
    tbl[5] = '{d: 10'd5, code: 14'h0006};
    tbl[6] = '{d: 10'd7, code: 14'h000A};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    datain = '0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_codeout", codeout, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(negedge clock);

    for (int i = 0; i < 7; i++) do_word(tbl[i].d, tbl[i].code, 2);

    for (int d = 0; d < 1024; d++) do_word(DW'(d), model_code(d), 3);

    // Back-to-back stream with out_ready tied high.
    for (int i = 0; i < 8; i++) words[i] = DW'($urandom_range(1, 1023));
    in_valid = 1'b1;
    out_ready = 1'b1;
    datain = words[0];
    acc_n = 0;
    rx_n = 0;
    last_acc = -1;
    started = 1'b0;
    cyc = 0;
    #1;
    while (cyc < 8 * 15 + 60 && !(acc_n == 8 && rx_n == 8)) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected_word", 1, 0);
        end else begin
          chk("b2b_codeout", codeout, model_code(int'(expq.pop_front())));
          rx_n++;
        end
      end
      if (started) chk("b2b_in_ready_only_done", in_ready, out_valid);
      acc_now = in_valid & in_ready;
      if (acc_now) begin
        if (last_acc >= 0) chk("b2b_period", cyc - last_acc, 15);
        last_acc = cyc;
        expq.push_back(datain);
        started = 1'b1;
      end
      @(negedge clock);
      cyc++;
      if (acc_now) begin
        acc_n++;
        if (acc_n < 8) datain = words[acc_n];
        else in_valid = 1'b0;
      end
      #1;
    end
    chk("b2b_accepted", acc_n, 8);
    chk("b2b_received", rx_n, 8);
    out_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Reset while digit 7 is about to resolve.
    datain = 10'd1000;
    in_valid = 1'b1;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    chk("midrst_accept", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_codeout", codeout, 0);
    chk("midrst_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_idle", in_ready, 1);
    do_word(10'd4, 14'h0005, 1);
    do_word(10'd1023, model_code(1023), 1);

`ifdef FNS_CAC_ENC_SELFCHECK_EN
    // Corrupt the last digit of a zero word: err must pulse with out_valid.
    datain = 10'd0;
    in_valid = 1'b1;
    #1;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (CW - 1) @(negedge clock);
    force dut.dig = 1'b1;
    @(negedge clock);
    release dut.dig;
    chk("selfcheck_out_valid", out_valid, 1);
    chk("selfcheck_err", err, 1);
    @(negedge clock);
    chk("selfcheck_err_pulse", err, 0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
